// File: rtl/lsu_byte_sequencer.sv
// Load/store byte sequencer: splits LB/LH/LW/SB/SH/SW into single-byte memory accesses.
// Optional MISALIGN_TRAP_EN: misaligned half/word requests respond at once with resp_err.
module lsu_byte_sequencer #(
  parameter int ADDR_WIDTH = 13,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [XLEN-1:0]       req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [7:0]            mem_data_in,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [7:0]            mem_data_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_n;
  logic                    we_q;
  logic                    uns_q;
  logic [1:0]              last_idx;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [XLEN-1:0]         wdata_q;
  logic [1:0]              idx;
  logic [XLEN-1:0]         lanes;
  logic [XLEN-1:0]         cur;
  logic [XLEN-1:0]         ext;
  logic [XLEN-1:0]         rdata_q;
  logic                    err_q;
  logic                    mis_req;
  logic                    last;
  logic [1:0]              req_last;
  logic                    unused_ok;

  assign unused_ok = ^req_addr[XLEN-1:ADDR_WIDTH];

`ifdef MISALIGN_TRAP_EN
  assign mis_req = (req_size == 2'b01 && req_addr[0]) ||
                   (req_size[1] && req_addr[1:0] != 2'b00);
`else
  assign mis_req = 1'b0;
`endif

  // Index of the final byte lane for the incoming request size.
  always_comb begin
    req_last = 2'd3;
    unique case (req_size)
      2'b00:   req_last = 2'd0;
      2'b01:   req_last = 2'd1;
      default: req_last = 2'd3;
    endcase
  end

  assign last = (idx == last_idx);

  // Load lanes with the byte arriving this cycle merged in.
  always_comb begin
    cur = lanes;
    unique case (idx)
      2'd0: cur[7:0]   = mem_data_out;
      2'd1: cur[15:8]  = mem_data_out;
      2'd2: cur[23:16] = mem_data_out;
      2'd3: cur[31:24] = mem_data_out;
      default: cur = lanes;
    endcase
  end

  // Sign/zero extension of the assembled load.
  always_comb begin
    ext = cur;
    unique case (last_idx)
      2'd0: ext = uns_q ? {{(XLEN-8){1'b0}}, cur[7:0]}
                        : {{(XLEN-8){cur[7]}}, cur[7:0]};
      2'd1: ext = uns_q ? {{(XLEN-16){1'b0}}, cur[15:0]}
                        : {{(XLEN-16){cur[15]}}, cur[15:0]};
      default: ext = cur;
    endcase
  end

  // Next-state logic: IDLE -> ACCESS -> RESP -> IDLE, trap skips ACCESS.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (req_valid) state_n = mis_req ? RESP : ACCESS;
      ACCESS:  if (last) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, latched request and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      last_idx <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      idx      <= 2'd0;
      lanes    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            uns_q    <= req_unsigned;
            last_idx <= req_last;
            addr_q   <= req_addr[ADDR_WIDTH-1:0];
            wdata_q  <= req_wdata;
            idx      <= 2'd0;
            lanes    <= '0;
            if (mis_req) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          idx <= idx + 2'd1;
          if (!we_q) lanes <= cur;
          if (last) begin
            rdata_q <= we_q ? '0 : ext;
            err_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory side decoded only from registered state.
  always_comb begin
    mem_data_in = wdata_q[7:0];
    unique case (idx)
      2'd0: mem_data_in = wdata_q[7:0];
      2'd1: mem_data_in = wdata_q[15:8];
      2'd2: mem_data_in = wdata_q[23:16];
      2'd3: mem_data_in = wdata_q[31:24];
      default: mem_data_in = wdata_q[7:0];
    endcase
  end

  assign mem_address = addr_q + ADDR_WIDTH'(idx);
  assign mem_wren    = (state == ACCESS) && we_q;
  assign mem_rden    = (state == ACCESS) && !we_q;
  assign req_ready   = (state == IDLE);
  assign resp_valid  = (state == RESP);
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;

endmodule
